mano_io_ctrl: RTL and testbench

- Input/output interface unit for the Mano basic computer core; sits directly beside the core.
- Supplies INPR and the FGI/FGO flags that INP, OUT, SKI and SKO consume.
- Latches OUTR from AC, holds the IEN interrupt-enable flip-flop and raises the interrupt request the core samples at T0.
- On the external side: a byte-wide valid/ready input stream buffered by a small FIFO, and a valid/ready output stream.

---
 rtl/mano_io_ctrl_if.sv | 22 ++
 rtl/mano_io_ctrl.sv | 120 ++++++++++++
 tb/tb_mano_io_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mano_io_ctrl_if.sv
// External byte streams of the Mano I/O unit: the input stream feeds the
// FIFO, and the output stream carries OUTR to the sink.
interface mano_io_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  // External producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // I/O unit side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mano_io_ctrl.sv
// Mano basic computer I/O unit: INPR/FGI fed from a small input FIFO,
// OUTR/FGO drained through a valid/ready output stream, IEN and irq.
module mano_io_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inp_rd,
  input  logic        out_wr,
  input  logic [15:0] ac_in,
  input  logic        ion,
  input  logic        iof,
  input  logic        int_ack,
  output logic [7:0]  inpr,
  output logic        fgi,
  output logic        fgo,
  output logic        ien,
  output logic        irq,
  output logic        ovr,
  mano_io_ctrl_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} out_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [7:0]    outr;
  out_state_t    state;
  logic          unused_ac;

  assign unused_ac = ^ac_in[15:8];

  // in_ready depends only on registered count, never on in_valid
  assign bus.in_ready = (count != FULL_CNT);
  assign push         = bus.in_valid & bus.in_ready;
  // Refill INPR whenever the flag is clear and a byte is waiting
  assign pop          = !fgi && (count != '0);

  assign bus.out_data = outr;
  assign irq          = ien & (fgi | fgo);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // INPR/FGI: refill uses pre-edge fgi, so refill and INP never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else if (pop) begin
      inpr <= mem[rd_ptr];
      fgi  <= 1'b1;
    end else if (inp_rd && fgi) begin
      fgi  <= 1'b0;
    end
  end

  // Output FSM with registered out_valid/fgo; OUT while busy flags overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      outr          <= '0;
      fgo           <= 1'b1;
      bus.out_valid <= 1'b0;
      ovr           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_wr) begin
            outr          <= ac_in[7:0];
            fgo           <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (out_wr) ovr <= 1'b1;
          if (bus.out_ready) begin
            fgo           <= 1'b1;
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt enable: int_ack beats iof beats ion
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ien <= 1'b0;
    else if (int_ack | iof) ien <= 1'b0;
    else if (ion)           ien <= 1'b1;
  end

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Bench for mano_io_ctrl: directed stimulus, expected bytes queued at issue
// time and checked by a negedge monitor on INP reads and output handshakes.
module tb_mano_io_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inp_rd = 1'b0, out_wr = 1'b0, ion = 1'b0, iof = 1'b0, int_ack = 1'b0;
  logic [15:0] ac_in = '0;
  logic [7:0]  inpr;
  logic        fgi, fgo, ien, irq, ovr;

  int passed = 0;
  int total  = 0;
  logic [7:0] in_exp[$];
  logic [7:0] out_exp[$];

  mano_io_ctrl_if bus();

  mano_io_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .inp_rd(inp_rd), .out_wr(out_wr), .ac_in(ac_in),
    .ion(ion), .iof(iof), .int_ack(int_ack), .inpr(inpr), .fgi(fgi),
    .fgo(fgo), .ien(ien), .irq(irq), .ovr(ovr), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every core INP read and every output handshake consumes one
  // expected byte; inputs are stable at negedge for the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (inp_rd && fgi) begin
        if (in_exp.size() == 0) chk("inpr unexpected read", {8'h0, inpr}, 16'hFFFF);
        else chk("inpr read", {8'h0, inpr}, {8'h0, in_exp.pop_front()});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_exp.size() == 0) chk("out unexpected byte", {8'h0, bus.out_data}, 16'hFFFF);
        else chk("out byte", {8'h0, bus.out_data}, {8'h0, out_exp.pop_front()});
      end
    end
  end

  // Wait for fgi (bounded) then perform one INP
  task automatic read_byte();
    int n = 0;
    while (!fgi && n < 20) begin tick(); n++; end
    chk("fgi wait", {15'h0, n < 20}, 16'h1);
    inp_rd = 1'b1;
    tick();
    inp_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst inpr", {8'h0, inpr}, 16'h0);
    chk("rst fgi", {15'h0, fgi}, 16'h0);
    chk("rst fgo", {15'h0, fgo}, 16'h1);
    chk("rst ien", {15'h0, ien}, 16'h0);
    chk("rst irq", {15'h0, irq}, 16'h0);
    chk("rst ovr", {15'h0, ovr}, 16'h0);
    chk("rst out_valid", {15'h0, bus.out_valid}, 16'h0);
    chk("rst in_ready", {15'h0, bus.in_ready}, 16'h1);
    rst = 1'b0;
    tick();

    // 1: single byte, two-edge latency to fgi
    bus.in_valid = 1'b1; bus.in_data = 8'h41; in_exp.push_back(8'h41);
    tick();
    bus.in_valid = 1'b0;
    chk("t1 fgi after push", {15'h0, fgi}, 16'h0);
    tick();
    chk("t1 fgi", {15'h0, fgi}, 16'h1);
    chk("t1 inpr", {8'h0, inpr}, 16'h0041);
    chk("t1 in_ready", {15'h0, bus.in_ready}, 16'h1);
    inp_rd = 1'b1;
    tick();
    inp_rd = 1'b0;
    chk("t1 fgi cleared", {15'h0, fgi}, 16'h0);
    chk("t1 inpr held", {8'h0, inpr}, 16'h0041);

    // 2: fill FIFO, stall 0x15, release with one INP, drain in order
    for (int b = 'h10; b <= 'h14; b++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(b); in_exp.push_back(8'(b));
      chk("t2 in_ready before push", {15'h0, bus.in_ready}, 16'h1);
      tick();
    end
    bus.in_data = 8'h15; in_exp.push_back(8'h15);
    tick(); tick();
    chk("t2 full stall", {15'h0, bus.in_ready}, 16'h0);
    chk("t2 inpr head", {8'h0, inpr}, 16'h0010);
    inp_rd = 1'b1;
    tick();
    inp_rd = 1'b0;
    chk("t2 fgi after inp", {15'h0, fgi}, 16'h0);
    chk("t2 still full", {15'h0, bus.in_ready}, 16'h0);
    tick();
    chk("t2 refill fgi", {15'h0, fgi}, 16'h1);
    chk("t2 refill inpr", {8'h0, inpr}, 16'h0011);
    chk("t2 in_ready back", {15'h0, bus.in_ready}, 16'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("t2 0x15 accepted", {15'h0, bus.in_ready}, 16'h0);
    repeat (5) read_byte();
    tick(); tick();
    chk("t2 drained fgi", {15'h0, fgi}, 16'h0);

    // 3: OUT with back-pressure
    out_wr = 1'b1; ac_in = 16'h12AB; out_exp.push_back(8'hAB);
    tick();
    out_wr = 1'b0;
    chk("t3 fgo", {15'h0, fgo}, 16'h0);
    chk("t3 out_valid", {15'h0, bus.out_valid}, 16'h1);
    chk("t3 out_data", {8'h0, bus.out_data}, 16'h00AB);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3 held", {7'h0, bus.out_valid, bus.out_data}, 16'h01AB);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3 fgo set", {15'h0, fgo}, 16'h1);
    chk("t3 out_valid clr", {15'h0, bus.out_valid}, 16'h0);
    chk("t3 ovr clean", {15'h0, ovr}, 16'h0);

    // 4: overrun while busy and on the handshake edge
    out_wr = 1'b1; ac_in = 16'h55AB; out_exp.push_back(8'hAB);
    tick();
    ac_in = 16'h00CD;
    tick();
    out_wr = 1'b0;
    chk("t4 ovr", {15'h0, ovr}, 16'h1);
    chk("t4 out_data kept", {8'h0, bus.out_data}, 16'h00AB);
    out_wr = 1'b1; bus.out_ready = 1'b1;
    tick();
    out_wr = 1'b0; bus.out_ready = 1'b0;
    chk("t4 ovr sticky", {15'h0, ovr}, 16'h1);
    chk("t4 fgo", {15'h0, fgo}, 16'h1);
    bus.out_ready = 1'b1;
    tick(); tick();
    bus.out_ready = 1'b0;
    chk("t4 no CD sent", {15'h0, bus.out_valid}, 16'h0);

    // 5: interrupt enable priority
    ion = 1'b1; tick(); ion = 1'b0;
    chk("t5 ien", {15'h0, ien}, 16'h1);
    chk("t5 irq", {15'h0, irq}, 16'h1);
    ion = 1'b1; int_ack = 1'b1; tick(); ion = 1'b0; int_ack = 1'b0;
    chk("t5 ion+ack ien", {15'h0, ien}, 16'h0);
    chk("t5 ion+ack irq", {15'h0, irq}, 16'h0);
    ion = 1'b1; tick(); ion = 1'b0;
    chk("t5 ien again", {15'h0, ien}, 16'h1);
    iof = 1'b1; tick(); iof = 1'b0;
    chk("t5 iof", {15'h0, ien}, 16'h0);
    ion = 1'b1; iof = 1'b1; tick(); ion = 1'b0; iof = 1'b0;
    chk("t5 ion+iof", {15'h0, ien}, 16'h0);

    // 6: async reset mid-SEND with bytes buffered (these bytes are discarded)
    ion = 1'b1; bus.in_valid = 1'b1;
    bus.in_data = 8'hA1; tick(); ion = 1'b0;
    bus.in_data = 8'hA2; tick();
    bus.in_data = 8'hA3; tick();
    bus.in_valid = 1'b0;
    out_wr = 1'b1; ac_in = 16'h00EE; tick(); out_wr = 1'b0;
    chk("t6 pre fgi", {15'h0, fgi}, 16'h1);
    chk("t6 pre out_valid", {15'h0, bus.out_valid}, 16'h1);
    chk("t6 pre ien", {15'h0, ien}, 16'h1);
    #1 rst = 1'b1;
    #1;
    chk("t6 async out_valid", {15'h0, bus.out_valid}, 16'h0);
    chk("t6 async fgo", {15'h0, fgo}, 16'h1);
    chk("t6 async fgi", {15'h0, fgi}, 16'h0);
    chk("t6 async inpr", {8'h0, inpr}, 16'h0);
    chk("t6 async ien", {15'h0, ien}, 16'h0);
    chk("t6 async ovr", {15'h0, ovr}, 16'h0);
    chk("t6 async in_ready", {15'h0, bus.in_ready}, 16'h1);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6 post fgi", {15'h0, fgi}, 16'h0);
    chk("t6 post inpr", {8'h0, inpr}, 16'h0);
    chk("t6 post fgo", {15'h0, fgo}, 16'h1);
    chk("t6 post in_ready", {15'h0, bus.in_ready}, 16'h1);
    chk("t6 post out_valid", {15'h0, bus.out_valid}, 16'h0);

    chk("in queue empty", 16'(in_exp.size()), 16'h0);
    chk("out queue empty", 16'(out_exp.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
